// File: rtl/iso_shift_port.sv
// Serial/parallel shift port for the isolator link: MSB-first TX and RX framed by srclk edges,
// with a valid/ready view of each received word. Define ISO_SHIFT_OVERRUN_EN for the overrun flag.
module iso_shift_port #(
   parameter int unsigned NUM_BITS = 8
) (
   input  logic                sclk,
   input  logic                reset_n,
   input  logic                srclk,
   input  logic [NUM_BITS-1:0] par_in,
   output logic                ser_out,
   input  logic                ser_in,
   output logic [NUM_BITS-1:0] par_out,
   output logic                out_valid,
   input  logic                out_ready,
`ifdef ISO_SHIFT_OVERRUN_EN
   output logic [NUM_BITS-1:0] out_data,
   output logic                overrun
`else
   output logic [NUM_BITS-1:0] out_data
`endif
);

   logic                srclk_q;
   logic                latch;
   logic [NUM_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [NUM_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [NUM_BITS-1:0] par_q, par_d;
   logic                valid_q, valid_d;

   always_comb begin
      latch   = srclk & ~srclk_q;
      tx_sr_d = latch ? par_in : {tx_sr_q[NUM_BITS-2:0], 1'b0};
      // The bit sampled on the latch edge belongs to the word being latched.
      rx_sr_d = {rx_sr_q[NUM_BITS-2:0], ser_in};
      par_d   = latch ? rx_sr_d : par_q;
      valid_d = valid_q;
      if (latch) begin
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         srclk_q <= 1'b0;
         tx_sr_q <= '0;
         rx_sr_q <= '0;
         par_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         srclk_q <= srclk;
         tx_sr_q <= tx_sr_d;
         rx_sr_q <= rx_sr_d;
         par_q   <= par_d;
         valid_q <= valid_d;
      end
   end

`ifdef ISO_SHIFT_OVERRUN_EN
   logic overrun_q, overrun_d;

   // Sticky: a new word replaced one nobody consumed.
   always_comb begin
      overrun_d = overrun_q | (latch & valid_q & ~out_ready);
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;
`endif

   assign ser_out   = tx_sr_q[NUM_BITS-1];
   assign par_out   = par_q;
   assign out_data  = par_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_iso_shift_port.sv
// Directed bench for iso_shift_port (NUM_BITS = 8): reset, TX/RX framing, loopback,
// overwrite and mid-frame reset.
module tb_iso_shift_port;

   localparam int unsigned NB = 8;

   logic          sclk = 1'b0;
   logic          reset_n;
   logic          srclk;
   logic [NB-1:0] par_in;
   logic          ser_out;
   logic          ser_in_drv;
   logic          loopback;
   logic          ser_in;
   logic [NB-1:0] par_out;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] out_data;
`ifdef ISO_SHIFT_OVERRUN_EN
   logic          overrun;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   assign ser_in = loopback ? ser_out : ser_in_drv;

   always #5 sclk = ~sclk;

   iso_shift_port #(
      .NUM_BITS(NB)
   ) dut (
      .sclk      (sclk),
      .reset_n   (reset_n),
      .srclk     (srclk),
      .par_in    (par_in),
      .ser_out   (ser_out),
      .ser_in    (ser_in),
      .par_out   (par_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef ISO_SHIFT_OVERRUN_EN
      .out_data  (out_data),
      .overrun   (overrun)
`else
      .out_data  (out_data)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   initial begin
      logic [NB-1:0] pat;
      logic [NB-1:0] words [4];

      reset_n    = 1'b0;
      srclk      = 1'b0;
      par_in     = '0;
      ser_in_drv = 1'b0;
      loopback   = 1'b0;
      out_ready  = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;

      // Idle after reset
      repeat (20) tick();
      check("idle_ser_out", 32'(ser_out), 32'd0);
      check("idle_par_out", 32'(par_out), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_out_data", 32'(out_data), 32'd0);
`ifdef ISO_SHIFT_OVERRUN_EN
      check("idle_overrun", 32'(overrun), 32'd0);
`endif

      // TX of 0xA5, MSB first, then zero fill
      pat       = 8'hA5;
      out_ready = 1'b1;
      par_in    = pat;
      srclk     = 1'b1;
      tick();
      check("tx_bit0", 32'(ser_out), 32'd1);
      srclk = 1'b0;
      for (int k = 1; k < NB; k++) begin
         tick();
         check($sformatf("tx_bit%0d", k), 32'(ser_out), 32'(pat[NB-1-k]));
      end
      repeat (2) begin
         tick();
         check("tx_zero_fill", 32'(ser_out), 32'd0);
      end

      // RX of 0x3C sampled on L+1..L+8, latched at L+8
      pat   = 8'h3C;
      srclk = 1'b1;
      tick();
      srclk = 1'b0;
      for (int k = 0; k < NB; k++) begin
         ser_in_drv = pat[NB-1-k];
         if (k == NB - 1) srclk = 1'b1;
         tick();
      end
      check("rx_par_out", 32'(par_out), 32'h3C);
      check("rx_valid", 32'(out_valid), 32'd1);
      srclk      = 1'b0;
      ser_in_drv = 1'b0;
      out_ready  = 1'b0;
      tick();
      check("rx_valid_held", 32'(out_valid), 32'd1);
      check("rx_out_data", 32'(out_data), 32'h3C);
      out_ready = 1'b1;
      tick();
      check("rx_consumed", 32'(out_valid), 32'd0);

      // Loopback: each word appears one frame later
      words[0] = 8'h12;
      words[1] = 8'h34;
      words[2] = 8'h56;
      words[3] = 8'h00;
      loopback = 1'b1;
      for (int f = 0; f < 4; f++) begin
         par_in = words[f];
         srclk  = 1'b1;
         tick();
         if (f > 0) begin
            check($sformatf("loop_word%0d", f - 1), 32'(out_data), 32'(words[f-1]));
            check($sformatf("loop_valid%0d", f - 1), 32'(out_valid), 32'd1);
         end
         srclk = 1'b0;
         repeat (NB - 1) tick();
      end
`ifdef ISO_SHIFT_OVERRUN_EN
      check("loop_no_overrun", 32'(overrun), 32'd0);
`endif

      // Unconsumed overwrite: 0x11 then 0x22 with out_ready low
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h00;
      out_ready = 1'b0;
      for (int f = 0; f < 3; f++) begin
         par_in = words[f];
         srclk  = 1'b1;
         tick();
         srclk = 1'b0;
         if (f < 2) repeat (NB - 1) tick();
      end
      check("ovw_out_data", 32'(out_data), 32'h22);
      check("ovw_valid", 32'(out_valid), 32'd1);
`ifdef ISO_SHIFT_OVERRUN_EN
      check("ovw_overrun", 32'(overrun), 32'd1);
`endif
      out_ready = 1'b1;
      tick();
      check("ovw_consumed", 32'(out_valid), 32'd0);
`ifdef ISO_SHIFT_OVERRUN_EN
      check("ovw_overrun_sticky", 32'(overrun), 32'd1);
`endif
      out_ready = 1'b0;
      loopback  = 1'b0;

      // Asynchronous reset at L+4 of a frame
      par_in     = 8'hFF;
      ser_in_drv = 1'b1;
      srclk      = 1'b1;
      tick();
      srclk = 1'b0;
      repeat (4) tick();
      check("pre_rst_ser_out", 32'(ser_out), 32'd1);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_par_out", 32'(par_out), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
`ifdef ISO_SHIFT_OVERRUN_EN
      check("rst_overrun", 32'(overrun), 32'd0);
`endif
      repeat (2) tick();
      check("rst_held_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1;
      tick();

      // Full frame after reset: TX 0xC3 out, RX 0x5A in
      pat    = 8'h5A;
      par_in = 8'hC3;
      srclk  = 1'b1;
      tick();
      check("post_tx_bit0", 32'(ser_out), 32'd1);
      srclk = 1'b0;
      for (int k = 0; k < NB; k++) begin
         ser_in_drv = pat[NB-1-k];
         if (k == NB - 1) srclk = 1'b1;
         tick();
         if (k == 1) check("post_tx_bit2", 32'(ser_out), 32'd0);
      end
      check("post_rx_par_out", 32'(par_out), 32'h5A);
      check("post_rx_valid", 32'(out_valid), 32'd1);
      srclk = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
